// File: rtl/cdb_arbiter.sv
// Common data bus arbiter: two small result FIFOs (ALU, LSB) drained one entry per
// cycle onto a registered CDB by a round-robin scheduler; misbranch flushes both queues.
module cdb_arbiter #(
  parameter int TAG_W      = 4,
  parameter int DATA_W     = 32,
  parameter int FIFO_DEPTH = 4,
  parameter int PTR_W      = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              in_alu_valid,
  input  logic [TAG_W-1:0]  in_alu_tag,
  input  logic [DATA_W-1:0] in_alu_value,
  output logic              out_alu_ready,
  input  logic              in_lsb_valid,
  input  logic [TAG_W-1:0]  in_lsb_tag,
  input  logic [DATA_W-1:0] in_lsb_value,
  input  logic              in_lsb_ioin,
  output logic              out_lsb_ready,
  input  logic              in_rob_misbranch,
  output logic [TAG_W-1:0]  out_cdb_tag,
  output logic [DATA_W-1:0] out_cdb_value,
  output logic              out_cdb_ioin,
  output logic              out_cdb_src
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
  localparam logic [PTR_W:0] CNT_ONE = (PTR_W+1)'(1);

  logic [TAG_W-1:0]  alu_tag_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] alu_val_mem [FIFO_DEPTH];
  logic [PTR_W-1:0]  alu_rd, alu_wr;
  logic [PTR_W:0]    alu_cnt;

  logic [TAG_W-1:0]  lsb_tag_mem [FIFO_DEPTH];
  logic [DATA_W-1:0] lsb_val_mem [FIFO_DEPTH];
  logic              lsb_io_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]  lsb_rd, lsb_wr;
  logic [PTR_W:0]    lsb_cnt;

  // prio = 0: ALU wins the next contested cycle; 1: LSB wins it.
  logic prio;

  logic active;
  logic alu_ne, lsb_ne;
  logic alu_push, lsb_push;
  logic grant_lsb;
  logic alu_pop, lsb_pop;

  // Ready reflects only the pre-edge count, so a full queue never accepts even when it pops.
  assign out_alu_ready = (alu_cnt != FULL_CNT);
  assign out_lsb_ready = (lsb_cnt != FULL_CNT);

  assign active    = rdy && !in_rob_misbranch;
  assign alu_ne    = (alu_cnt != '0);
  assign lsb_ne    = (lsb_cnt != '0);
  assign alu_push  = active && in_alu_valid && out_alu_ready && (in_alu_tag != '0);
  assign lsb_push  = active && in_lsb_valid && out_lsb_ready && (in_lsb_tag != '0);
  assign grant_lsb = lsb_ne && (!alu_ne || prio);
  assign alu_pop   = active && alu_ne && !grant_lsb;
  assign lsb_pop   = active && grant_lsb;

  always_ff @(posedge clk) begin
    if (alu_push) begin
      alu_tag_mem[alu_wr] <= in_alu_tag;
      alu_val_mem[alu_wr] <= in_alu_value;
    end
    if (lsb_push) begin
      lsb_tag_mem[lsb_wr] <= in_lsb_tag;
      lsb_val_mem[lsb_wr] <= in_lsb_value;
      lsb_io_mem[lsb_wr]  <= in_lsb_ioin;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      alu_rd        <= '0;
      alu_wr        <= '0;
      alu_cnt       <= '0;
      lsb_rd        <= '0;
      lsb_wr        <= '0;
      lsb_cnt       <= '0;
      prio          <= 1'b0;
      out_cdb_tag   <= '0;
      out_cdb_value <= '0;
      out_cdb_ioin  <= 1'b0;
      out_cdb_src   <= 1'b0;
    end else if (rdy) begin
      if (in_rob_misbranch) begin
        alu_rd      <= '0;
        alu_wr      <= '0;
        alu_cnt     <= '0;
        lsb_rd      <= '0;
        lsb_wr      <= '0;
        lsb_cnt     <= '0;
        prio        <= 1'b0;
        out_cdb_tag <= '0;
      end else begin
        if (alu_push) alu_wr <= alu_wr + PTR_ONE;
        if (alu_pop)  alu_rd <= alu_rd + PTR_ONE;
        if (alu_push && !alu_pop)      alu_cnt <= alu_cnt + CNT_ONE;
        else if (!alu_push && alu_pop) alu_cnt <= alu_cnt - CNT_ONE;

        if (lsb_push) lsb_wr <= lsb_wr + PTR_ONE;
        if (lsb_pop)  lsb_rd <= lsb_rd + PTR_ONE;
        if (lsb_push && !lsb_pop)      lsb_cnt <= lsb_cnt + CNT_ONE;
        else if (!lsb_push && lsb_pop) lsb_cnt <= lsb_cnt - CNT_ONE;

        // Round-robin pointer only moves when both queues competed for the bus.
        if (alu_ne && lsb_ne) prio <= !grant_lsb;

        if (alu_pop) begin
          out_cdb_tag   <= alu_tag_mem[alu_rd];
          out_cdb_value <= alu_val_mem[alu_rd];
          out_cdb_ioin  <= 1'b0;
          out_cdb_src   <= 1'b0;
        end else if (lsb_pop) begin
          out_cdb_tag   <= lsb_tag_mem[lsb_rd];
          out_cdb_value <= lsb_val_mem[lsb_rd];
          out_cdb_ioin  <= lsb_io_mem[lsb_rd];
          out_cdb_src   <= 1'b1;
        end else begin
          out_cdb_tag <= '0;
        end
      end
    end
  end

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed bench for cdb_arbiter: each task drives one scenario and checks the CDB
// against hand-derived tag/value/source tables.
module tb_cdb_arbiter;
  localparam int TAG_W  = 4;
  localparam int DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic              rdy;
  logic              in_alu_valid;
  logic [TAG_W-1:0]  in_alu_tag;
  logic [DATA_W-1:0] in_alu_value;
  logic              out_alu_ready;
  logic              in_lsb_valid;
  logic [TAG_W-1:0]  in_lsb_tag;
  logic [DATA_W-1:0] in_lsb_value;
  logic              in_lsb_ioin;
  logic              out_lsb_ready;
  logic              in_rob_misbranch;
  logic [TAG_W-1:0]  out_cdb_tag;
  logic [DATA_W-1:0] out_cdb_value;
  logic              out_cdb_ioin;
  logic              out_cdb_src;

  int vectors = 0;
  int miscompares = 0;

  cdb_arbiter #(.TAG_W(TAG_W), .DATA_W(DATA_W), .FIFO_DEPTH(4), .PTR_W(2)) dut (
    .clk(clk), .rst(rst), .rdy(rdy),
    .in_alu_valid(in_alu_valid), .in_alu_tag(in_alu_tag), .in_alu_value(in_alu_value),
    .out_alu_ready(out_alu_ready),
    .in_lsb_valid(in_lsb_valid), .in_lsb_tag(in_lsb_tag), .in_lsb_value(in_lsb_value),
    .in_lsb_ioin(in_lsb_ioin), .out_lsb_ready(out_lsb_ready),
    .in_rob_misbranch(in_rob_misbranch),
    .out_cdb_tag(out_cdb_tag), .out_cdb_value(out_cdb_value),
    .out_cdb_ioin(out_cdb_ioin), .out_cdb_src(out_cdb_src)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver tasks
  function automatic logic [DATA_W-1:0] alu_val(input logic [TAG_W-1:0] t);
    return 32'hA000_0000 | DATA_W'(t);
  endfunction

  function automatic logic [DATA_W-1:0] lsb_val(input logic [TAG_W-1:0] t);
    return 32'hB000_0000 | DATA_W'(t);
  endfunction

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic idle;
    rdy = 1'b1;
    in_rob_misbranch = 1'b0;
    in_alu_valid = 1'b0;
    in_alu_tag = '0;
    in_alu_value = '0;
    in_lsb_valid = 1'b0;
    in_lsb_tag = '0;
    in_lsb_value = '0;
    in_lsb_ioin = 1'b0;
  endtask

  task automatic drive_alu(input logic [TAG_W-1:0] t);
    in_alu_valid = 1'b1;
    in_alu_tag = t;
    in_alu_value = alu_val(t);
  endtask

  task automatic drive_lsb(input logic [TAG_W-1:0] t, input logic io);
    in_lsb_valid = 1'b1;
    in_lsb_tag = t;
    in_lsb_value = lsb_val(t);
    in_lsb_ioin = io;
  endtask

  task automatic do_reset;
    idle();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  // Scenario tasks
  task automatic test_reset;
    do_reset();
    vectors++;
    if (out_cdb_tag !== '0 || out_cdb_value !== '0 || out_cdb_ioin !== 1'b0 || out_cdb_src !== 1'b0) begin
      $display("FAIL reset_outputs: tag=%0d value=%h ioin=%b src=%b, want all 0",
               out_cdb_tag, out_cdb_value, out_cdb_ioin, out_cdb_src);
      miscompares++;
    end
    vectors++;
    if (out_alu_ready !== 1'b1 || out_lsb_ready !== 1'b1) begin
      $display("FAIL reset_ready: alu=%b lsb=%b, want 1 1", out_alu_ready, out_lsb_ready);
      miscompares++;
    end
    // Load two entries, then reset with rdy low and misbranch high mid-stream.
    drive_alu(4); tick();
    drive_alu(5); tick();
    vectors++;
    if (out_cdb_tag !== 4'd4) begin
      $display("FAIL reset_prestream: tag=%0d, want 4", out_cdb_tag);
      miscompares++;
    end
    idle();
    rdy = 1'b0;
    in_rob_misbranch = 1'b1;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle();
    vectors++;
    if (out_cdb_tag !== '0 || out_cdb_value !== '0 || out_cdb_src !== 1'b0) begin
      $display("FAIL reset_midstream: tag=%0d value=%h src=%b, want 0", out_cdb_tag, out_cdb_value, out_cdb_src);
      miscompares++;
    end
    tick();
    vectors++;
    if (out_cdb_tag !== '0) begin
      $display("FAIL reset_lost_entry: tag=%0d, want 0", out_cdb_tag);
      miscompares++;
    end
  endtask

  task automatic test_single;
    do_reset();
    in_alu_valid = 1'b1; in_alu_tag = 4'd3; in_alu_value = 32'h11;
    tick();
    vectors++;
    if (out_cdb_tag !== '0) begin
      $display("FAIL single_edge1: tag=%0d, want 0", out_cdb_tag);
      miscompares++;
    end
    // Tag 0 offered here must be dropped.
    in_alu_valid = 1'b1; in_alu_tag = 4'd0; in_alu_value = 32'h99;
    tick();
    vectors++;
    if (out_cdb_tag !== 4'd3 || out_cdb_value !== 32'h11 || out_cdb_src !== 1'b0 || out_cdb_ioin !== 1'b0) begin
      $display("FAIL single_edge2: tag=%0d value=%h src=%b ioin=%b, want 3 00000011 0 0",
               out_cdb_tag, out_cdb_value, out_cdb_src, out_cdb_ioin);
      miscompares++;
    end
    idle();
    tick();
    vectors++;
    if (out_cdb_tag !== '0) begin
      $display("FAIL single_edge3: tag=%0d, want 0 (tag-0 push dropped)", out_cdb_tag);
      miscompares++;
    end
  endtask

  task automatic test_back_to_back;
    logic [TAG_W-1:0] exp_t [8];
    exp_t = '{4'd0, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11, 4'd0};
    do_reset();
    for (int e = 0; e < 8; e++) begin
      idle();
      if (e < 3) begin
        drive_alu(TAG_W'(e + 1));
        drive_lsb(TAG_W'(e + 9), 1'b0);
      end
      tick();
      vectors++;
      if (out_cdb_tag !== exp_t[e]) begin
        $display("FAIL b2b_tag[%0d]: tag=%0d, want %0d", e, out_cdb_tag, exp_t[e]);
        miscompares++;
      end else if (exp_t[e] != '0) begin
        vectors++;
        if (out_cdb_src !== (exp_t[e] >= 9) ||
            out_cdb_value !== ((exp_t[e] >= 9) ? lsb_val(exp_t[e]) : alu_val(exp_t[e]))) begin
          $display("FAIL b2b_data[%0d]: value=%h src=%b for tag %0d", e, out_cdb_value, out_cdb_src, exp_t[e]);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_full;
    logic [TAG_W-1:0] exp_t [15];
    logic exp_ar [8];
    logic exp_lr [8];
    exp_t  = '{4'd0, 4'd1, 4'd9, 4'd2, 4'd10, 4'd3, 4'd11, 4'd4,
               4'd12, 4'd5, 4'd13, 4'd6, 4'd14, 4'd7, 4'd0};
    exp_ar = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    exp_lr = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    do_reset();
    for (int e = 0; e < 15; e++) begin
      idle();
      if (e < 8) drive_alu(TAG_W'(e + 1));
      if (e < 7) drive_lsb(TAG_W'(e + 9), 1'b0);
      if (e < 8) begin
        vectors++;
        if (out_alu_ready !== exp_ar[e] || out_lsb_ready !== exp_lr[e]) begin
          $display("FAIL full_ready[%0d]: alu=%b lsb=%b, want %b %b",
                   e, out_alu_ready, out_lsb_ready, exp_ar[e], exp_lr[e]);
          miscompares++;
        end
      end
      tick();
      vectors++;
      if (out_cdb_tag !== exp_t[e]) begin
        $display("FAIL full_tag[%0d]: tag=%0d, want %0d", e, out_cdb_tag, exp_t[e]);
        miscompares++;
      end else if (exp_t[e] != '0) begin
        vectors++;
        if (out_cdb_src !== (exp_t[e] >= 9) ||
            out_cdb_value !== ((exp_t[e] >= 9) ? lsb_val(exp_t[e]) : alu_val(exp_t[e]))) begin
          $display("FAIL full_data[%0d]: value=%h src=%b for tag %0d", e, out_cdb_value, out_cdb_src, exp_t[e]);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_misbranch;
    logic [TAG_W-1:0] exp_t [8];
    exp_t = '{4'd0, 4'd1, 4'd0, 4'd0, 4'd0, 4'd4, 4'd12, 4'd0};
    do_reset();
    for (int e = 0; e < 8; e++) begin
      idle();
      case (e)
        0: begin drive_alu(1); drive_lsb(9, 1'b0); end
        1: begin drive_alu(2); drive_lsb(10, 1'b0); end
        2: begin drive_alu(3); drive_lsb(11, 1'b0); in_rob_misbranch = 1'b1; end
        4: begin drive_alu(4); drive_lsb(12, 1'b0); end
        default: ;
      endcase
      tick();
      vectors++;
      if (out_cdb_tag !== exp_t[e]) begin
        $display("FAIL misbranch_tag[%0d]: tag=%0d, want %0d", e, out_cdb_tag, exp_t[e]);
        miscompares++;
      end
      if (e == 2 || e == 3) begin
        vectors++;
        if (out_alu_ready !== 1'b1 || out_lsb_ready !== 1'b1) begin
          $display("FAIL misbranch_ready[%0d]: alu=%b lsb=%b, want 1 1", e, out_alu_ready, out_lsb_ready);
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_freeze;
    logic [TAG_W-1:0] exp_t [7];
    exp_t = '{4'd0, 4'd5, 4'd5, 4'd5, 4'd5, 4'd6, 4'd0};
    do_reset();
    for (int e = 0; e < 7; e++) begin
      idle();
      case (e)
        0: drive_alu(5);
        1: drive_alu(6);
        2, 3, 4: begin
          rdy = 1'b0;
          drive_alu(7);
          drive_lsb(8, 1'b1);
          if (e == 3) in_rob_misbranch = 1'b1;
        end
        default: ;
      endcase
      tick();
      vectors++;
      if (out_cdb_tag !== exp_t[e]) begin
        $display("FAIL freeze_tag[%0d]: tag=%0d, want %0d", e, out_cdb_tag, exp_t[e]);
        miscompares++;
      end else if (exp_t[e] != '0) begin
        vectors++;
        if (out_cdb_value !== alu_val(exp_t[e]) || out_cdb_src !== 1'b0) begin
          $display("FAIL freeze_data[%0d]: value=%h src=%b, want %h 0", e, out_cdb_value, out_cdb_src, alu_val(exp_t[e]));
          miscompares++;
        end
      end
    end
  endtask

  task automatic test_wrap;
    logic [TAG_W-1:0] exp_t [12];
    logic exp_io [12];
    logic exp_src [12];
    exp_t   = '{4'd0, 4'd7, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd7, 4'd8, 4'd12, 4'd0};
    exp_io  = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
    exp_src = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    do_reset();
    for (int e = 0; e < 12; e++) begin
      idle();
      if (e == 0) drive_lsb(7, 1'b1);
      else if (e <= 8) drive_lsb(TAG_W'(e), e[0]);
      else if (e == 9) begin
        drive_alu(12);
        in_lsb_ioin = 1'b1;
      end
      tick();
      vectors++;
      if (out_cdb_tag !== exp_t[e]) begin
        $display("FAIL wrap_tag[%0d]: tag=%0d, want %0d", e, out_cdb_tag, exp_t[e]);
        miscompares++;
      end else if (exp_t[e] != '0) begin
        vectors++;
        if (out_cdb_ioin !== exp_io[e] || out_cdb_src !== exp_src[e] ||
            out_cdb_value !== (exp_src[e] ? lsb_val(exp_t[e]) : alu_val(exp_t[e]))) begin
          $display("FAIL wrap_data[%0d]: value=%h ioin=%b src=%b, want ioin=%b src=%b",
                   e, out_cdb_value, out_cdb_ioin, out_cdb_src, exp_io[e], exp_src[e]);
          miscompares++;
        end
      end
    end
  endtask

  // Sequence and final report
  initial begin
    idle();
    rst = 1'b1;
    test_reset();
    test_single();
    test_back_to_back();
    test_full();
    test_misbranch();
    test_freeze();
    test_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
